// File: rtl/conv_pkg.sv
// Shared types and constants for the parametrised convolution engine.
package conv_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IN_DIM = 4;
  localparam int DEF_K_DIM  = 3;

  localparam logic LD_SEL_INPUT  = 1'b0;
  localparam logic LD_SEL_FILTER = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Unsigned multiply-accumulate with synchronous clear and enable.
// sum is the value the accumulator loads next, so a caller can capture the final tap without waiting a cycle.
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0]    acc_reg;
  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign sum  = acc_reg + ACC_W'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/param_conv_engine.sv
// Single-MAC sliding-window convolution engine with loadable input/filter buffers.
// Define CONV_SAT_EN to saturate results to all-ones instead of truncating.
module param_conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IN_DIM = DEF_IN_DIM,
  parameter int K_DIM  = DEF_K_DIM
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ld_valid,
  input  logic                                   ld_sel,
  input  logic [clog2(IN_DIM*IN_DIM)-1:0]        ld_addr,
  input  logic [DATA_W-1:0]                      ld_data,
  output logic                                   ld_ready,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_W-1:0]                      out_data,
  output logic [clog2(IN_DIM-K_DIM+1)-1:0]       out_row,
  output logic [clog2(IN_DIM-K_DIM+1)-1:0]       out_col
);

  localparam int OUT_DIM = IN_DIM - K_DIM + 1;
  localparam int ACC_W   = 2*DATA_W + clog2(K_DIM*K_DIM);
  localparam int AW      = clog2(IN_DIM*IN_DIM);
  localparam int OW      = clog2(OUT_DIM);
  localparam int IN_N    = IN_DIM*IN_DIM;
  localparam int K_N     = K_DIM*K_DIM;
  localparam int TW      = (K_DIM > 1) ? clog2(K_DIM) : 1;
  localparam int FW      = (K_N > 1) ? clog2(K_N) : 1;
  localparam logic [AW:0] IN_N_W = (AW+1)'(IN_N);
  localparam logic [AW:0] K_N_W  = (AW+1)'(K_N);

  state_t state_reg, state_next;

  logic [OW-1:0]     row_reg, col_reg;
  logic [TW-1:0]     tr_reg, tc_reg;
  logic [DATA_W-1:0] in_mem  [IN_N];
  logic [DATA_W-1:0] flt_mem [K_N];
  logic [DATA_W-1:0] out_data_reg;
  logic [OW-1:0]     out_row_reg, out_col_reg;

  logic              wr_en, in_wr, flt_wr;
  logic              last_tap, last_pix, launch, accept;
  logic              mac_clr, mac_en;
  logic [AW-1:0]     in_addr;
  logic [FW-1:0]     flt_addr;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] result;

  assign wr_en  = ld_valid && (state_reg == IDLE);
  assign in_wr  = wr_en && (ld_sel == LD_SEL_INPUT)  && ({1'b0, ld_addr} < IN_N_W);
  assign flt_wr = wr_en && (ld_sel == LD_SEL_FILTER) && ({1'b0, ld_addr} < K_N_W);

  assign last_tap = (tr_reg == TW'(K_DIM-1)) && (tc_reg == TW'(K_DIM-1));
  assign last_pix = (row_reg == OW'(OUT_DIM-1)) && (col_reg == OW'(OUT_DIM-1));
  assign launch   = (state_reg == IDLE) && start;
  assign accept   = (state_reg == OUT) && out_ready;
  assign mac_clr  = launch || accept;
  assign mac_en   = (state_reg == CALC);

  always_comb begin
    in_addr  = AW'((int'(row_reg) + int'(tr_reg)) * IN_DIM + int'(col_reg) + int'(tc_reg));
    flt_addr = FW'(int'(tr_reg) * K_DIM + int'(tc_reg));
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (in_mem[in_addr]),
    .b   (flt_mem[flt_addr]),
    .sum (sum)
  );

`ifdef CONV_SAT_EN
  assign result = (|sum[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
  logic unused_hi;
  assign result    = sum[DATA_W-1:0];
  assign unused_hi = ^sum[ACC_W-1:DATA_W];
`endif

  // Buffers write only in IDLE, so a write alongside start lands before the first MAC reads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IN_N; i++) in_mem[i] <= '0;
      for (int i = 0; i < K_N; i++)  flt_mem[i] <= '0;
    end else begin
      for (int i = 0; i < IN_N; i++) begin
        if (in_wr && (ld_addr == AW'(i))) in_mem[i] <= ld_data;
      end
      for (int i = 0; i < K_N; i++) begin
        if (flt_wr && (ld_addr == AW'(i))) flt_mem[i] <= ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        ld_ready = 1'b1;
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_tap) state_next = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = last_pix ? DONE : CALC;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg      <= '0;
      col_reg      <= '0;
      tr_reg       <= '0;
      tc_reg       <= '0;
      out_data_reg <= '0;
      out_row_reg  <= '0;
      out_col_reg  <= '0;
    end else begin
      if (launch) begin
        row_reg <= '0;
        col_reg <= '0;
        tr_reg  <= '0;
        tc_reg  <= '0;
      end
      if (state_reg == CALC) begin
        if (last_tap) begin
          tr_reg       <= '0;
          tc_reg       <= '0;
          out_data_reg <= result;
          out_row_reg  <= row_reg;
          out_col_reg  <= col_reg;
        end else if (tc_reg == TW'(K_DIM-1)) begin
          tc_reg <= '0;
          tr_reg <= tr_reg + TW'(1);
        end else begin
          tc_reg <= tc_reg + TW'(1);
        end
      end
      if (accept && !last_pix) begin
        if (col_reg == OW'(OUT_DIM-1)) begin
          col_reg <= '0;
          row_reg <= row_reg + OW'(1);
        end else begin
          col_reg <= col_reg + OW'(1);
        end
      end
    end
  end

  assign out_data = out_data_reg;
  assign out_row  = out_row_reg;
  assign out_col  = out_col_reg;

endmodule

// File: tb/tb_param_conv_engine.sv
// Scoreboard bench: default engine (4x4 / 3x3 / 8-bit) plus a 5x5 / 2x2 / 4-bit instance.
// Latencies are counted from the cycle in which start is driven (that cycle's closing edge is cycle 1).
module tb_param_conv_engine;
  import conv_pkg::*;

`ifdef CONV_SAT_EN
  localparam int SAT_EXP = 255;
`else
  localparam int SAT_EXP = 9;
`endif

  logic clk, rst;

  logic       ld_valid_a, ld_sel_a, ld_ready_a, start_a, busy_a, done_a;
  logic       out_valid_a, out_ready_a;
  logic [3:0] ld_addr_a;
  logic [7:0] ld_data_a, out_data_a;
  logic [0:0] out_row_a, out_col_a;

  logic       ld_valid_b, ld_sel_b, ld_ready_b, start_b, busy_b, done_b;
  logic       out_valid_b, out_ready_b;
  logic [4:0] ld_addr_b;
  logic [3:0] ld_data_b, out_data_b;
  logic [1:0] out_row_b, out_col_b;

  typedef struct {int d; int r; int c;} exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_pass   = 0;
  int basic_exp[4] = '{54, 63, 90, 99};

  param_conv_engine dut_a (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid_a), .ld_sel(ld_sel_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a),
    .ld_ready(ld_ready_a), .start(start_a), .busy(busy_a), .done(done_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_row(out_row_a), .out_col(out_col_a)
  );

  param_conv_engine #(.DATA_W(4), .IN_DIM(5), .K_DIM(2)) dut_b (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid_b), .ld_sel(ld_sel_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b),
    .ld_ready(ld_ready_b), .start(start_b), .busy(busy_b), .done(done_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_row(out_row_b), .out_col(out_col_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) check("a_unexpected_output", 1, 0);
      else begin
        e = q_a.pop_front();
        $display("a out (%0d,%0d) = %0d", out_row_a, out_col_a, out_data_a);
        check("a_data", out_data_a, e.d);
        check("a_row", out_row_a, e.r);
        check("a_col", out_col_a, e.c);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) check("b_unexpected_output", 1, 0);
      else begin
        e = q_b.pop_front();
        $display("b out (%0d,%0d) = %0d", out_row_b, out_col_b, out_data_b);
        check("b_data", out_data_b, e.d);
        check("b_row", out_row_b, e.r);
        check("b_col", out_col_b, e.c);
      end
    end
  end

  task automatic wr_a(input logic sel, input int addr, input int data);
    ld_valid_a = 1'b1; ld_sel_a = sel; ld_addr_a = 4'(addr); ld_data_a = 8'(data);
    @(posedge clk); #1;
    ld_valid_a = 1'b0;
  endtask

  task automatic wr_b(input logic sel, input int addr, input int data);
    ld_valid_b = 1'b1; ld_sel_b = sel; ld_addr_b = 5'(addr); ld_data_b = 4'(data);
    @(posedge clk); #1;
    ld_valid_b = 1'b0;
  endtask

  task automatic load_basic_a();
    for (int i = 0; i < 16; i++) wr_a(LD_SEL_INPUT, i, i + 1);
    for (int i = 0; i < 9; i++)  wr_a(LD_SEL_FILTER, i, 1);
  endtask

  task automatic push_basic();
    for (int i = 0; i < 4; i++) q_a.push_back('{basic_exp[i], i / 2, i % 2});
  endtask

  task automatic run_a(input string tag, input int stall, input int inject_at,
                       input int reset_at, input int exp_first, input int exp_done);
    int cnt, first_at, done_at, stall_left;
    bit stalled, aborted;
    cnt = 0; first_at = 0; done_at = 0; stall_left = 0; stalled = 0; aborted = 0;
    start_a = 1'b1;
    while (done_at == 0 && !aborted && cnt < 300) begin
      @(posedge clk); cnt++; #1;
      if (cnt == 1) begin start_a = 1'b0; ld_valid_a = 1'b0; end
      if (out_valid_a && first_at == 0) first_at = cnt;
      if (done_a) done_at = cnt;
      if (stall > 0 && !stalled && out_valid_a && out_row_a == 1'b0 && out_col_a == 1'b1) begin
        stalled = 1; stall_left = stall; out_ready_a = 1'b0;
      end else if (stall_left > 0) begin
        check({tag, "_stall_valid"}, out_valid_a, 1);
        check({tag, "_stall_data"}, out_data_a, 63);
        stall_left--;
        if (stall_left == 0) out_ready_a = 1'b1;
      end
      if (inject_at > 0 && cnt == inject_at) begin
        start_a = 1'b1; ld_valid_a = 1'b1; ld_sel_a = LD_SEL_FILTER; ld_addr_a = 4'd0; ld_data_a = 8'd7;
      end
      if (inject_at > 0 && cnt == inject_at + 1) begin start_a = 1'b0; ld_valid_a = 1'b0; end
      if (reset_at > 0 && cnt == reset_at) begin
        rst = 1'b0; #1;
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_out_valid"}, out_valid_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_ld_ready"}, ld_ready_a, 1);
        check({tag, "_out_data"}, out_data_a, 0);
        q_a.delete();
        aborted = 1;
        @(posedge clk); #1;
        rst = 1'b1;
      end
    end
    if (!aborted) begin
      check({tag, "_first_valid_cycle"}, first_at, exp_first);
      check({tag, "_done_cycle"}, done_at, exp_done);
      check({tag, "_all_outputs_seen"}, q_a.size(), 0);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, done_a, 0);
      check({tag, "_ld_ready_after"}, ld_ready_a, 1);
    end
  endtask

  task automatic run_b(input int exp_first, input int exp_done);
    int cnt, first_at, done_at;
    cnt = 0; first_at = 0; done_at = 0;
    start_b = 1'b1;
    while (done_at == 0 && cnt < 300) begin
      @(posedge clk); cnt++; #1;
      if (cnt == 1) start_b = 1'b0;
      if (out_valid_b && first_at == 0) first_at = cnt;
      if (done_b) done_at = cnt;
    end
    check("b_first_valid_cycle", first_at, exp_first);
    check("b_done_cycle", done_at, exp_done);
    check("b_all_outputs_seen", q_b.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    ld_valid_a = 0; ld_sel_a = 0; ld_addr_a = '0; ld_data_a = '0; start_a = 0; out_ready_a = 1;
    ld_valid_b = 0; ld_sel_b = 0; ld_addr_b = '0; ld_data_b = '0; start_b = 0; out_ready_b = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ld_ready", ld_ready_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_out_valid", out_valid_a, 0);
    check("reset_out_data", out_data_a, 0);
    check("reset_out_row", out_row_a, 0);
    check("reset_out_col", out_col_a, 0);
    check("reset_b_ld_ready", ld_ready_b, 1);
    check("reset_b_busy", busy_b, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic run; the out-of-range filter write at address 9 must not disturb anything.
    load_basic_a();
    wr_a(LD_SEL_FILTER, 9, 7);
    push_basic();
    run_a("basic", 0, 0, 0, 10, 41);

    push_basic();
    run_a("backpressure", 5, 0, 0, 10, 46);

    push_basic();
    run_a("ignored_req", 0, 5, 0, 10, 41);

    // Reset during pixel (1,0) CALC, then a run on the cleared buffers yields zeros.
    push_basic();
    run_a("midrun_rst", 0, 0, 24, 0, 0);
    for (int i = 0; i < 4; i++) q_a.push_back('{0, i / 2, i % 2});
    run_a("cleared", 0, 0, 0, 10, 41);

    // Reload with the last filter tap written in the same cycle as start.
    for (int i = 0; i < 16; i++) wr_a(LD_SEL_INPUT, i, i + 1);
    for (int i = 0; i < 8; i++)  wr_a(LD_SEL_FILTER, i, 1);
    ld_valid_a = 1'b1; ld_sel_a = LD_SEL_FILTER; ld_addr_a = 4'd8; ld_data_a = 8'd1;
    push_basic();
    run_a("reload", 0, 0, 0, 10, 41);

    for (int i = 0; i < 16; i++) wr_a(LD_SEL_INPUT, i, 255);
    for (int i = 0; i < 9; i++)  wr_a(LD_SEL_FILTER, i, 255);
    for (int i = 0; i < 4; i++) q_a.push_back('{SAT_EXP, i / 2, i % 2});
    run_a("saturation", 0, 0, 0, 10, 41);

    for (int i = 0; i < 25; i++) wr_b(LD_SEL_INPUT, i, 1);
    for (int i = 0; i < 4; i++)  wr_b(LD_SEL_FILTER, i, 1);
    for (int i = 0; i < 16; i++) q_b.push_back('{4, i / 4, i % 4});
    run_b(5, 81);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_conv_engine.md
Name: param_conv_engine

Overview:
Parametrised single-MAC sliding-window convolution engine. It is the successor to the fixed 4x4-input / 3x3-filter / 8-bit engines, generalised in data width, input size and kernel size. Input and filter buffers are loaded through a write port, a run is started with a start pulse, and outputs stream in row-major order over a valid/ready handshake. It sits between memory and the display path, under the controller.

Parameters:
DATA_W, 8, width of input, filter and output samples (unsigned)
IN_DIM, 4, input feature map is IN_DIM x IN_DIM
K_DIM, 3, filter is K_DIM x K_DIM
Derived (localparam, not overridable):
- OUT_DIM = IN_DIM-K_DIM+1
- ACC_W = 2*DATA_W+clog2(K_DIM*K_DIM)
- AW = clog2(IN_DIM*IN_DIM)
- OW = clog2(OUT_DIM)
Legal range: K_DIM>=1, IN_DIM>=K_DIM+1 (so OUT_DIM>=2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ld_valid  in  1  buffer write strobe
ld_sel  in  1  0 = input buffer, 1 = filter buffer
ld_addr  in  AW  row-major buffer index
ld_data  in  DATA_W  write data
ld_ready  out  1  high only in IDLE
start  in  1  single-cycle run request
busy  out  1  high in CALC/OUT
done  out  1  one-cycle pulse at end of run
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  result pixel
out_row  out  OW  result row index
out_col  out  OW  result column index

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0 except ld_ready=1.
  - Both buffers, the accumulator and the row/col/tap counters cleared to 0.
  - A reset during a run aborts it with no done pulse.
- Buffer writes:
  - A write occurs when ld_valid && ld_ready.
  - Filter writes with ld_addr>=K_DIM*K_DIM are ignored; input writes with ld_addr>=IN_DIM*IN_DIM are ignored.
  - ld_valid is ignored outside IDLE.
- FSM:
  - IDLE: start=1 -> CALC. The row/col/tap counters and accumulator clear on this edge. A simultaneous ld_valid in the same cycle as start is still written, and the data becomes visible to the run.
  - CALC: one MAC per cycle, acc += in[(row+tr)*IN_DIM+(col+tc)] * flt[tr*K_DIM+tc], with the tap index advancing tc first, then tr. After tap K_DIM*K_DIM-1 -> OUT. Results are registered into out_data/out_row/out_col on that transition.
  - OUT: out_valid=1; out_data/out_row/out_col are held stable until out_ready=1. On acceptance:
    - if (row,col) is the last pixel -> DONE;
    - otherwise advance col (wrapping to 0 and incrementing row), clear the accumulator, -> CALC.
  - DONE: done=1 for one cycle -> IDLE.
- Handshake and timing:
  - start while busy is ignored.
  - With out_ready tied high, each pixel takes K_DIM*K_DIM+1 cycles.
  - The first out_valid appears K_DIM*K_DIM+1 cycles after the start edge.
  - done asserts OUT_DIM^2*(K_DIM*K_DIM+1)+1 cycles after the start edge.
- Arithmetic: unsigned, with a full-precision ACC_W accumulator (no internal overflow). Output reduction is governed by the optional feature.

Optional Feature:
Macro CONV_SAT_EN.
- Defined: out_data = all-ones if acc > 2^DATA_W-1, else acc[DATA_W-1:0].
- Undefined: out_data = acc[DATA_W-1:0] (wrap-around truncation, matching the previous fixed-size engines).

Decomposition:
- Package conv_pkg holds:
  - state enum (IDLE, CALC, OUT, DONE);
  - clog2 constant function;
  - default DATA_W/IN_DIM/K_DIM constants;
  - LD_SEL_INPUT/LD_SEL_FILTER encodings.
- One sub-module, conv_mac: ACC_W accumulator with clear and enable, taking DATA_W x DATA_W operands.
- Buffers, address generation and the FSM stay in param_conv_engine.

Test Plan:
- Basic run (defaults, out_ready=1): load input 1..16 row-major and filter all 1, pulse start. Expect four outputs in order:
  - (0,0)=54, (0,1)=63, (1,0)=90, (1,1)=99;
  - first out_valid 10 cycles after start, done pulse 41 cycles after start.
- Saturation: input all 255, filter all 255. Expect every out_data=255 with CONV_SAT_EN defined, and 9 (585225 mod 256) without it.
- Backpressure: basic run with out_ready held low for 5 cycles at pixel (0,1). out_valid stays high, data stays 63, no counter progress, done is delayed by 5 cycles.
- Ignored requests:
  - start and ld_valid (filter addr 0, data 7) asserted during CALC: no restart and filter unchanged, so outputs still match the basic run;
  - filter write at addr 9 in IDLE is ignored.
- Mid-run reset: drive rst=0 during CALC of pixel (1,0). Expect immediate busy=0, out_valid=0, done=0, ld_ready=1. After reload and restart, the basic-run results are reproduced.
- Generic sizing: IN_DIM=5, K_DIM=2, DATA_W=4, input all 1, filter all 1. Expect 16 outputs equal to 4, and done 81 cycles after start.
